hamming_secded_dec: RTL and testbench

- Parametrised, pipelined SECDED Hamming decoder. Generalises the team's fixed (15,11) single-error decoder to any (2^R-1, 2^R-1-R) code plus an overall parity bit, giving double-error detection.
- Sits between the memory/link receive path and CPU consumers.
- Valid/ready handshake on both sides; fixed 2-cycle latency; full throughput.
- Provides a detect-only mode and saturating error counters for health monitoring.

---
 rtl/hamming_secded_dec_if.sv | 38 +++
 rtl/hamming_secded_dec.sv | 140 ++++++++++++++
 tb/tb_hamming_secded_dec.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hamming_secded_dec_if.sv
// Handshake and data bundle for the SECDED decoder.
// master drives codewords in and accepts decoded words; slave is the decoder.
interface hamming_secded_dec_if #(
  parameter int R     = 4,
  parameter int CNT_W = 16
);
  localparam int N = (1 << R) - 1;
  localparam int K = N - R;

  logic             in_valid;
  logic             in_ready;
  logic [N:0]       in_code;
  logic             correct_en;
  logic             cnt_clr;
  logic             out_valid;
  logic             out_ready;
  logic [N:0]       out_code;
  logic [K-1:0]     out_data;
  logic             out_single;
  logic             out_double;
  logic [R-1:0]     out_syndrome;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] ded_cnt;

  modport master (
    output in_valid, in_code, correct_en, cnt_clr, out_ready,
    input  in_ready, out_valid, out_code, out_data,
    input  out_single, out_double, out_syndrome,
    input  sec_cnt, ded_cnt
  );

  modport slave (
    input  in_valid, in_code, correct_en, cnt_clr, out_ready,
    output in_ready, out_valid, out_code, out_data,
    output out_single, out_double, out_syndrome,
    output sec_cnt, ded_cnt
  );
endinterface

// File: rtl/hamming_secded_dec.sv
// Two-stage SECDED Hamming decoder with detect-only mode
// and saturating single/double error counters.
module hamming_secded_dec #(
  parameter int R     = 4,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  hamming_secded_dec_if.slave bus
);
  localparam int N = (1 << R) - 1;
  localparam int K = N - R;

  logic             s1_valid_q, s1_valid_d;
  logic [N:0]       s1_code_q, s1_code_d;
  logic [R-1:0]     s1_syn_q, s1_syn_d;
  logic             s1_par_q, s1_par_d;
  logic             s1_cen_q, s1_cen_d;
  logic             out_valid_q, out_valid_d;
  logic [N:0]       out_code_q, out_code_d;
  logic [K-1:0]     out_data_q, out_data_d;
  logic             out_single_q, out_single_d;
  logic             out_double_q, out_double_d;
  logic [R-1:0]     out_syn_q, out_syn_d;
  logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
  logic [CNT_W-1:0] ded_cnt_q, ded_cnt_d;

  logic         s2_en, s1_en, ld1, ld2;
  logic [R-1:0] syn_c;
  logic         par_c;
  logic [N:0]   fix_c;
  logic [K-1:0] data_c;
  logic         single_c, double_c;

  assign s2_en = ~out_valid_q | bus.out_ready;
  assign s1_en = ~s1_valid_q | s2_en;
  assign ld1   = s1_en & bus.in_valid;
  assign ld2   = s2_en & s1_valid_q;

  // Syndrome and overall parity of the incoming word
  always_comb begin
    syn_c = '0;
    for (int p = 1; p <= N; p++) begin
      if (bus.in_code[N-p]) syn_c = syn_c ^ R'(p);
    end
    par_c = ^bus.in_code;
  end

  // Classify and, if enabled, flip the offending bit
  always_comb begin
    single_c = s1_par_q;
    double_c = (s1_syn_q != '0) & ~s1_par_q;
    fix_c    = s1_code_q;
    if (s1_cen_q && s1_par_q) begin
      if (s1_syn_q == '0) begin
        fix_c[N] = ~fix_c[N];
      end else begin
        for (int p = 1; p <= N; p++) begin
          if (R'(p) == s1_syn_q) fix_c[N-p] = ~fix_c[N-p];
        end
      end
    end
  end

  // Data bits are the non-power-of-two positions, ascending
  for (genvar p = 3; p <= N; p++) begin : g_data
    if ((p & (p - 1)) != 0) begin : g_bit
      assign data_c[p-1-$clog2(p)] = fix_c[N-p];
    end
  end

  // Next state for both pipeline stages and counters
  always_comb begin
    s1_valid_d   = s1_en ? bus.in_valid : s1_valid_q;
    s1_code_d    = ld1 ? bus.in_code : s1_code_q;
    s1_syn_d     = ld1 ? syn_c : s1_syn_q;
    s1_par_d     = ld1 ? par_c : s1_par_q;
    s1_cen_d     = ld1 ? bus.correct_en : s1_cen_q;
    out_valid_d  = s2_en ? s1_valid_q : out_valid_q;
    out_code_d   = ld2 ? fix_c : out_code_q;
    out_data_d   = ld2 ? data_c : out_data_q;
    out_single_d = ld2 ? single_c : out_single_q;
    out_double_d = ld2 ? double_c : out_double_q;
    out_syn_d    = ld2 ? s1_syn_q : out_syn_q;
    sec_cnt_d    = sec_cnt_q;
    ded_cnt_d    = ded_cnt_q;
    if (bus.cnt_clr) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else begin
      if (ld2 && single_c && !(&sec_cnt_q))
        sec_cnt_d = sec_cnt_q + 1'b1;
      if (ld2 && double_c && !(&ded_cnt_q))
        ded_cnt_d = ded_cnt_q + 1'b1;
    end
  end

  // State registers; reset drops everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_code_q    <= '0;
      s1_syn_q     <= '0;
      s1_par_q     <= 1'b0;
      s1_cen_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_code_q   <= '0;
      out_data_q   <= '0;
      out_single_q <= 1'b0;
      out_double_q <= 1'b0;
      out_syn_q    <= '0;
      sec_cnt_q    <= '0;
      ded_cnt_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_code_q    <= s1_code_d;
      s1_syn_q     <= s1_syn_d;
      s1_par_q     <= s1_par_d;
      s1_cen_q     <= s1_cen_d;
      out_valid_q  <= out_valid_d;
      out_code_q   <= out_code_d;
      out_data_q   <= out_data_d;
      out_single_q <= out_single_d;
      out_double_q <= out_double_d;
      out_syn_q    <= out_syn_d;
      sec_cnt_q    <= sec_cnt_d;
      ded_cnt_q    <= ded_cnt_d;
    end
  end

  assign bus.in_ready     = s1_en;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_code     = out_code_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_single   = out_single_q;
  assign bus.out_double   = out_double_q;
  assign bus.out_syndrome = out_syn_q;
  assign bus.sec_cnt      = sec_cnt_q;
  assign bus.ded_cnt      = ded_cnt_q;
endmodule

// File: tb/tb_hamming_secded_dec.sv
// Directed bench for hamming_secded_dec, R=4 and 2-bit counters
// so saturation is reached within a handful of words.
module tb_hamming_secded_dec;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  hamming_secded_dec_if #(.R(4), .CNT_W(2)) bus ();

  hamming_secded_dec #(.R(4), .CNT_W(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic xfer(input string tag, input logic [15:0] code,
                      input logic cen, input logic clr,
                      input logic [15:0] e_code, input logic [10:0] e_data,
                      input logic e_s, input logic e_d,
                      input logic [3:0] e_syn,
                      input logic [1:0] e_sec, input logic [1:0] e_ded);
    @(posedge clk); #1;
    bus.in_valid   = 1'b1;
    bus.in_code    = code;
    bus.correct_en = cen;
    bus.out_ready  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid   = 1'b0;
    bus.correct_en = ~cen;
    bus.cnt_clr    = clr;
    @(posedge clk); #1;
    bus.cnt_clr    = 1'b0;
    check({tag, ".valid"}, bus.out_valid, 1);
    check({tag, ".code"}, bus.out_code, e_code);
    check({tag, ".data"}, bus.out_data, e_data);
    check({tag, ".single"}, bus.out_single, e_s);
    check({tag, ".double"}, bus.out_double, e_d);
    check({tag, ".syn"}, bus.out_syndrome, e_syn);
    check({tag, ".sec"}, bus.sec_cnt, e_sec);
    check({tag, ".ded"}, bus.ded_cnt, e_ded);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [15:0] words [8];
  logic [15:0] exps  [8];
  int          idx;
  int          oidx;
  bit          stalled_prev;
  bit          saw_bp;
  logic [15:0] held;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n          = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_code    = '0;
    bus.correct_en = 1'b1;
    bus.cnt_clr    = 1'b0;
    bus.out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst.in_ready", bus.in_ready, 1);
    check("rst.out_valid", bus.out_valid, 0);
    check("rst.code", bus.out_code, 0);
    check("rst.sec", bus.sec_cnt, 0);
    check("rst.ded", bus.ded_cnt, 0);

    xfer("clean0", 16'h0000, 1, 0, 16'h0000, 11'h000, 0, 0, 4'h0, 0, 0);
    xfer("clean1", 16'hFFFF, 1, 0, 16'hFFFF, 11'h7FF, 0, 0, 4'h0, 0, 0);
    xfer("cleanD", 16'hF000, 1, 0, 16'hF000, 11'h001, 0, 0, 4'h0, 0, 0);
    xfer("fixP6",  16'hF200, 1, 0, 16'hF000, 11'h001, 1, 0, 4'h6, 1, 0);
    xfer("fixP1",  16'h4000, 1, 0, 16'h0000, 11'h000, 1, 0, 4'h1, 2, 0);
    xfer("fixPar", 16'h8000, 1, 0, 16'h0000, 11'h000, 1, 0, 4'h0, 3, 0);
    xfer("dbl",    16'h4001, 1, 0, 16'h4001, 11'h400, 0, 1, 4'hE, 3, 1);
    xfer("det1",   16'h4000, 0, 0, 16'h4000, 11'h000, 1, 0, 4'h1, 3, 1);
    xfer("det3",   16'h1000, 0, 0, 16'h1000, 11'h001, 1, 0, 4'h3, 3, 1);
    xfer("clr",    16'h4000, 1, 1, 16'h0000, 11'h000, 1, 0, 4'h1, 0, 0);
    xfer("post",   16'h8000, 1, 0, 16'h0000, 11'h000, 1, 0, 4'h0, 1, 0);

    words = '{16'h0000, 16'hF000, 16'hF200, 16'hFFFF,
              16'h4000, 16'h8000, 16'h1000, 16'h0FFF};
    exps  = '{16'h0000, 16'hF000, 16'hF000, 16'hFFFF,
              16'h0000, 16'h0000, 16'h0000, 16'h0FFF};
    idx = 0;
    oidx = 0;
    stalled_prev = 1'b0;
    saw_bp = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 40 && oidx < 8; cyc++) begin
      @(posedge clk); #1;
      bus.out_ready  = !(cyc >= 3 && cyc <= 5);
      bus.in_valid   = (idx < 8);
      bus.in_code    = words[(idx < 8) ? idx : 0];
      bus.correct_en = 1'b1;
      @(negedge clk);
      if (stalled_prev) begin
        check("stall.code", bus.out_code, held);
        check("stall.valid", bus.out_valid, 1);
      end
      stalled_prev = bus.out_valid && !bus.out_ready;
      held = bus.out_code;
      if (bus.in_valid && !bus.in_ready) saw_bp = 1'b1;
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("stream%0d", oidx), bus.out_code, exps[oidx]);
        oidx++;
      end
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("stream.count", oidx, 8);
    check("stream.in_idx", idx, 8);
    check("stream.bp", saw_bp, 1);
    check("stream.sec", bus.sec_cnt, 3);

    bus.in_code    = 16'h4000;
    bus.correct_en = 1'b1;
    bus.in_valid   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("mid.valid_pre", bus.out_valid, 1);
    check("mid.sec_pre", bus.sec_cnt, 3);
    rst_n = 1'b0;
    #1;
    check("mid.valid", bus.out_valid, 0);
    check("mid.single", bus.out_single, 0);
    check("mid.code", bus.out_code, 0);
    check("mid.sec", bus.sec_cnt, 0);
    check("mid.ded", bus.ded_cnt, 0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("mid.in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    check("mid.flushed", bus.out_valid, 0);
    check("mid.sec_post", bus.sec_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
